sseg_mux_driver: RTL and testbench

//  Parametrised time-multiplexed seven-segment driver for N common-select digits on the FMC LED socket.

---
 rtl/sseg_mux_driver.sv | 170 +++++++++++++++++
 tb/tb_sseg_mux_driver.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sseg_mux_driver.sv
// Time-multiplexed seven-segment driver: per-slot blanking, 16-step PWM brightness,
// per-digit enable, hex or raw patterns, and a frame strobe at the start of slot 0.
module sseg_mux_driver #(
    parameter int N_DIGITS     = 4,
    parameter int BLANK_CYCLES = 1000,
    parameter int ON_CYCLES    = 99008,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit SEL_ACT_LOW  = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [4*N_DIGITS-1:0]   i_hex,
    input  logic [N_DIGITS-1:0]     i_dp,
    input  logic [8*N_DIGITS-1:0]   i_raw,
    input  logic                    i_raw_mode,
    input  logic [N_DIGITS-1:0]     i_digit_en,
    input  logic [3:0]              i_bright,
    output logic [7:0]              o_sseg_n,
    output logic [N_DIGITS-1:0]     o_ldsel,
    output logic                    o_frame_strobe
);

    localparam int SUB_CYCLES = ON_CYCLES / 16;
    localparam int CTR_MAX    = (BLANK_CYCLES > SUB_CYCLES) ? BLANK_CYCLES : SUB_CYCLES;
    localparam int CTR_W      = $clog2(CTR_MAX + 1);
    localparam int IDX_W      = $clog2(N_DIGITS);

    localparam logic [CTR_W-1:0]    BLANK_LAST = CTR_W'(BLANK_CYCLES - 1);
    localparam logic [CTR_W-1:0]    SUB_LAST   = CTR_W'(SUB_CYCLES - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [7:0]          SEG_OFF    = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] SEL_IDLE   = SEL_ACT_LOW ? '1 : '0;

    typedef enum logic {ST_BLANK, ST_ON} state_t;

    state_t               state_q, state_d;
    logic [CTR_W-1:0]     ctr_q, ctr_d;
    logic [3:0]           sub_q, sub_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           pat_q, pat_d;
    logic                 en_q, en_d;
    logic [3:0]           bright_q, bright_d;
    logic [7:0]           sseg_q, sseg_d;
    logic [N_DIGITS-1:0]  ldsel_q, ldsel_d;
    logic                 strobe_q, strobe_d;

    logic                 slot_entry;
    logic                 lit;
    logic [3:0]           nib;
    logic [7:0]           raw_pat;
    logic                 dp_bit;
    logic                 en_bit;
    logic [N_DIGITS-1:0]  sel_hot;

    // Active-high segment decode {g,f,e,d,c,b,a}; b and d are lower-case glyphs.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        sub_d    = sub_q;
        idx_d    = idx_q;
        pat_d    = pat_q;
        en_d     = en_q;
        bright_d = bright_q;
        nib      = '0;
        raw_pat  = '0;
        dp_bit   = 1'b0;
        en_bit   = 1'b0;
        sel_hot  = '0;

        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib        = i_hex[4*k +: 4];
                raw_pat    = i_raw[8*k +: 8];
                dp_bit     = i_dp[k];
                en_bit     = i_digit_en[k];
                sel_hot[k] = 1'b1;
            end
        end

        // Everything shown during a slot is captured once, so mid-slot input changes never glitch.
        slot_entry = (state_q == ST_BLANK) && (ctr_q == '0);
        if (slot_entry) begin
            pat_d    = i_raw_mode ? raw_pat : {dp_bit, hex_to_seg(nib)};
            en_d     = en_bit;
            bright_d = i_bright;
        end

        case (state_q)
            ST_BLANK: begin
                if (ctr_q == BLANK_LAST) begin
                    state_d = ST_ON;
                    ctr_d   = '0;
                    sub_d   = '0;
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end
            default: begin
                if (ctr_q == SUB_LAST) begin
                    ctr_d = '0;
                    if (sub_q == 4'hF) begin
                        state_d = ST_BLANK;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    end else begin
                        sub_d = sub_q + 4'd1;
                    end
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end
        endcase

        lit      = (state_q == ST_ON) && en_q && (sub_q <= bright_q);
        ldsel_d  = lit ? (SEL_ACT_LOW ? ~sel_hot : sel_hot) : SEL_IDLE;
        sseg_d   = lit ? (SEG_ACT_LOW ? ~pat_q : pat_q) : SEG_OFF;
        strobe_d = slot_entry && (idx_q == '0);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_BLANK;
            ctr_q    <= '0;
            sub_q    <= '0;
            idx_q    <= '0;
            pat_q    <= '0;
            en_q     <= 1'b0;
            bright_q <= '0;
            sseg_q   <= SEG_OFF;
            ldsel_q  <= SEL_IDLE;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            sub_q    <= sub_d;
            idx_q    <= idx_d;
            pat_q    <= pat_d;
            en_q     <= en_d;
            bright_q <= bright_d;
            sseg_q   <= sseg_d;
            ldsel_q  <= ldsel_d;
            strobe_q <= strobe_d;
        end
    end

    assign o_sseg_n       = sseg_q;
    assign o_ldsel        = ldsel_q;
    assign o_frame_strobe = strobe_q;

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Bench for sseg_mux_driver with short slots (2 blank + 16 on clocks, 4 digits).
module tb_sseg_mux_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] hex = '0;
    logic [3:0]  dp = '0;
    logic [31:0] raw = '0;
    logic        raw_mode = 1'b0;
    logic [3:0]  en = '0;
    logic [3:0]  bright = '0;
    logic [7:0]  sseg_n;
    logic [3:0]  ldsel;
    logic        strobe;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_seg[8];

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [31:0] raw;
        logic        raw_mode;
        logic [3:0]  en;
        logic [3:0]  b;
        logic [31:0] seg;
    } vec_t;

    vec_t vecs[7];

    sseg_mux_driver #(
        .N_DIGITS(4), .BLANK_CYCLES(2), .ON_CYCLES(16), .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b0)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_hex(hex), .i_dp(dp), .i_raw(raw),
        .i_raw_mode(raw_mode), .i_digit_en(en), .i_bright(bright),
        .o_sseg_n(sseg_n), .o_ldsel(ldsel), .o_frame_strobe(strobe)
    );

    always #5 clk = ~clk;

    // Output invariants on every cycle once outputs are defined.
    always @(negedge clk) begin
        if (!$isunknown({ldsel, sseg_n})) begin
            total++;
            if (!$onehot0(ldsel) || (ldsel == 4'b0000 && sseg_n != 8'hFF)) begin
                bad++;
                $display("FAIL invariant t=%0t ldsel=%b sseg_n=%h required onehot0 and FF when idle",
                         $time, ldsel, sseg_n);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_segs(input logic [31:0] seg);
        for (int s = 0; s < 8; s++) exp_seg[s] = seg[8*(s%4) +: 8];
    endtask

    task automatic reset_release(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) tick();
        rst_n = 1'b1;
    endtask

    // Cycle t counts output cycles after reset release, the first posedge with rst_n=1 being t=1.
    task automatic run_trace(input string name, input int t0, input int t1,
                             input logic [3:0] b, input logic [3:0] e);
        int n_sel, n_seg, n_stb, f_t;
        logic [31:0] f_sel_a, f_sel_e, f_seg_a, f_seg_e, f_stb_a, f_stb_e;
        n_sel = 0; n_seg = 0; n_stb = 0; f_t = 0;
        f_sel_a = '0; f_sel_e = '0; f_seg_a = '0; f_seg_e = '0; f_stb_a = '0; f_stb_e = '0;
        for (int t = t0; t <= t1; t++) begin
            int slot, pos, d;
            logic lit;
            logic [3:0] x_sel;
            logic [7:0] x_seg;
            logic x_stb;
            tick();
            slot  = (t - 1) / 18;
            pos   = (t - 1) % 18;
            d     = slot % 4;
            lit   = (pos >= 2) && ((pos - 2) <= int'(b)) && e[d];
            x_sel = lit ? (4'b0001 << d) : 4'b0000;
            x_seg = lit ? exp_seg[slot % 8] : 8'hFF;
            x_stb = ((t - 1) % 72) == 0;
            if (ldsel !== x_sel) begin
                if (n_sel == 0) begin f_sel_a = 32'(ldsel); f_sel_e = 32'(x_sel); f_t = t; end
                n_sel++;
            end
            if (sseg_n !== x_seg) begin
                if (n_seg == 0) begin f_seg_a = 32'(sseg_n); f_seg_e = 32'(x_seg); f_t = t; end
                n_seg++;
            end
            if (strobe !== x_stb) begin
                if (n_stb == 0) begin f_stb_a = 32'(strobe); f_stb_e = 32'(x_stb); f_t = t; end
                n_stb++;
            end
        end
        total += 3;
        if (n_sel != 0) begin
            bad++;
            $display("FAIL %s ldsel (%0d cycles, first t=%0d) actual=%h required=%h", name, n_sel, f_t, f_sel_a, f_sel_e);
        end
        if (n_seg != 0) begin
            bad++;
            $display("FAIL %s sseg_n (%0d cycles, first t=%0d) actual=%h required=%h", name, n_seg, f_t, f_seg_a, f_seg_e);
        end
        if (n_stb != 0) begin
            bad++;
            $display("FAIL %s strobe (%0d cycles, first t=%0d) actual=%h required=%h", name, n_stb, f_t, f_stb_a, f_stb_e);
        end
    endtask

    initial begin
        // seg field: digit k expected o_sseg_n (active-low) at [8k+7:8k]
        vecs[0] = '{16'h3210, 4'h0, 32'h0, 1'b0, 4'hF, 4'd15, 32'hB0A4F9C0};
        vecs[1] = '{16'h3210, 4'h0, 32'h0, 1'b0, 4'hF, 4'd0,  32'hB0A4F9C0};
        vecs[2] = '{16'h3210, 4'h0, 32'h0, 1'b0, 4'hF, 4'd7,  32'hB0A4F9C0};
        vecs[3] = '{16'h3210, 4'h0, 32'h0, 1'b0, 4'b1011, 4'd15, 32'hB0A4F9C0};
        vecs[4] = '{16'hFFFF, 4'hF, 32'h36FF0180, 1'b1, 4'hF, 4'd15, 32'hC900FE7F};
        vecs[5] = '{16'h8DBA, 4'b0101, 32'h0, 1'b0, 4'hF, 4'd15, 32'h80218308};
        vecs[6] = '{16'hFEC9, 4'h0, 32'h0, 1'b0, 4'hF, 4'd3,  32'h8E86C690};

        // Reset held: outputs idle every cycle.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_hold", {19'h0, strobe, ldsel, sseg_n}, {19'h0, 1'b0, 4'b0000, 8'hFF});
        end

        for (int v = 0; v < 7; v++) begin
            hex = vecs[v].hex; dp = vecs[v].dp; raw = vecs[v].raw;
            raw_mode = vecs[v].raw_mode; en = vecs[v].en; bright = vecs[v].b;
            set_segs(vecs[v].seg);
            reset_release(2);
            run_trace($sformatf("vec%0d", v), 1, 144, vecs[v].b, vecs[v].en);
        end

        // Hex change mid-ON of digit 1 takes effect from digit 2's slot on.
        hex = 16'h3210; dp = 4'h0; raw_mode = 1'b0; en = 4'hF; bright = 4'd15;
        set_segs(32'hB0A4F9C0);
        reset_release(2);
        run_trace("midchg_a", 1, 24, 4'd15, 4'hF);
        hex = 16'h8888;
        for (int s = 2; s < 8; s++) exp_seg[s] = 8'h80;
        run_trace("midchg_b", 25, 144, 4'd15, 4'hF);

        // Reset pulse mid-ON of digit 2, then scan restarts at digit 0 with a strobe.
        hex = 16'h3210;
        set_segs(32'hB0A4F9C0);
        reset_release(2);
        run_trace("midrst_pre", 1, 43, 4'd15, 4'hF);
        rst_n = 1'b0;
        tick();
        chk("midrst_idle", {19'h0, strobe, ldsel, sseg_n}, {19'h0, 1'b0, 4'b0000, 8'hFF});
        tick();
        rst_n = 1'b1;
        run_trace("midrst_post", 1, 72, 4'd15, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
